// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// ----------------
// Receive-side monitor for a multiplexed, active-low seven-segment display.
// It samples the segment and anode bus and waits for the bus to hold still.
// It then reconstructs the hex value shown on each digit.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   seg_n[6:0]   active-low segments, bit6..bit0 = g,f,e,d,c,b,a
//   an_n[N-1:0]  active-low digit enables, bit i = digit i
//   digit_val    decoded nibble per digit, digit i in bits [4i+3:4i]
//   digit_valid  digit holds a captured legal glyph
//   digit_blank  last capture on the digit was all-off (7'h7F)
//   digit_err    sticky: an illegal pattern was captured on the digit
//   upd          one-cycle pulse per capture
//   upd_idx      digit index of the current capture (0 when upd = 0)
//
// Optional feature
//   SEGDEC_TIMEOUT_EN
//     When this macro is defined, each digit gets a refresh watchdog.
//     Once TIMEOUT_CYCLES cycles pass without a capture, the watchdog clears
//     digit_valid and digit_blank for that digit.
//
// Pipeline
//   Edge k     {an_n, seg_n} is registered and the stability counter restarts.
//   Edge k+S-1 the counter reaches STABLE_CYCLES-1 and a capture request is
//              registered.
//   Edge k+S   the per-digit state and upd/upd_idx update.
//   The outputs are driven from registers only.

module seg_scan_decoder #(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] digit_val,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    upd,
  output logic [2:0]              upd_idx
);

  localparam int SW = NUM_DIGITS + 7;
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CNT_FIRE = 8'(STABLE_CYCLES - 2);
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Glyph decoder.
  // The result is {legal, nibble}.
  // The all-off pattern is handled separately by the caller.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [4:0] res;
    res = 5'b0_0000;
    case (seg)
      7'h40: res = {1'b1, 4'h0};
      7'h79: res = {1'b1, 4'h1};
      7'h24: res = {1'b1, 4'h2};
      7'h30: res = {1'b1, 4'h3};
      7'h19: res = {1'b1, 4'h4};
      7'h12: res = {1'b1, 4'h5};
      7'h02: res = {1'b1, 4'h6};
      7'h78: res = {1'b1, 4'h7};
      7'h00: res = {1'b1, 4'h8};
      7'h10: res = {1'b1, 4'h9};
      7'h08: res = {1'b1, 4'hA};
      7'h03: res = {1'b1, 4'hB};
      7'h46: res = {1'b1, 4'hC};
      7'h21: res = {1'b1, 4'hD};
      7'h06: res = {1'b1, 4'hE};
      7'h0E: res = {1'b1, 4'hF};
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Input stage and stability counter
  // ---------------------------------------------------------------------------
  logic [SW-1:0] sample_reg;
  logic [SW-1:0] sample_next;
  logic [7:0]    cnt_reg;
  logic          match;

  assign sample_next = {an_n, seg_n};
  assign match       = (sample_next == sample_reg);

  // Anode qualification.
  // Count the active (low) enables and remember which digit is selected.
  // A capture is allowed only when exactly one digit is selected.
  logic [3:0] an_low_cnt;
  logic [2:0] an_idx;
  logic       an_onehot;

  always_comb begin
    an_low_cnt = 4'd0;
    an_idx     = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_n[i]) begin
        an_low_cnt = an_low_cnt + 4'd1;
        an_idx     = 3'(i);
      end
    end
    an_onehot = (an_low_cnt == 4'd1);
  end

  // The counter lands on CNT_LAST exactly once per stable window.
  // After that it saturates, so a held pattern cannot fire again.
  // A blanking gap or ghosting pattern still advances the counter.
  // It only blocks the capture request.
  logic       fire_next;
  logic       fire_reg;
  logic [2:0] fire_idx_reg;
  logic [6:0] fire_seg_reg;

  assign fire_next = match && (cnt_reg == CNT_FIRE) && an_onehot;

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_reg   <= '1;
      cnt_reg      <= 8'd0;
      fire_reg     <= 1'b0;
      fire_idx_reg <= 3'd0;
      fire_seg_reg <= SEG_BLANK;
    end else begin
      sample_reg <= sample_next;
      if (!match) begin
        cnt_reg <= 8'd0;
      end else if (cnt_reg != CNT_LAST) begin
        cnt_reg <= cnt_reg + 8'd1;
      end
      fire_reg     <= fire_next;
      fire_idx_reg <= an_idx;
      fire_seg_reg <= seg_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture stage
  // ---------------------------------------------------------------------------
  logic [4:0] dec;
  logic       cap_blank;
  logic       cap_legal;

  assign dec       = decode_glyph(fire_seg_reg);
  assign cap_blank = (fire_seg_reg == SEG_BLANK);
  assign cap_legal = dec[4];

  always_ff @(posedge clk) begin
    if (rst) begin
      upd     <= 1'b0;
      upd_idx <= 3'd0;
    end else begin
      upd     <= fire_reg;
      upd_idx <= fire_reg ? fire_idx_reg : 3'd0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] val_reg;
      logic       valid_reg;
      logic       blank_reg;
      logic       err_reg;
      logic       cap_here;

      assign cap_here = fire_reg && (fire_idx_reg == 3'(gi));

`ifdef SEGDEC_TIMEOUT_EN
      localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [TW-1:0] AGE_MAX = TW'(TIMEOUT_CYCLES);
      logic [TW-1:0] age_reg;
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          val_reg   <= 4'd0;
          valid_reg <= 1'b0;
          blank_reg <= 1'b0;
          err_reg   <= 1'b0;
`ifdef SEGDEC_TIMEOUT_EN
          age_reg   <= '0;
`endif
        end else if (cap_here) begin
`ifdef SEGDEC_TIMEOUT_EN
          age_reg <= '0;
`endif
          if (cap_blank) begin
            // Blank capture: the last shown value stays readable.
            valid_reg <= 1'b0;
            blank_reg <= 1'b1;
          end else if (cap_legal) begin
            val_reg   <= dec[3:0];
            valid_reg <= 1'b1;
            blank_reg <= 1'b0;
          end else begin
            // Illegal glyph: the value holds and the error latches.
            // blank tracks only the most recent capture, so it clears here.
            valid_reg <= 1'b0;
            blank_reg <= 1'b0;
            err_reg   <= 1'b1;
          end
        end else begin
`ifdef SEGDEC_TIMEOUT_EN
          // Refresh watchdog.
          // The counter saturates at AGE_MAX.
          // valid and blank clear on the edge the counter reaches it.
          if (age_reg != AGE_MAX) begin
            age_reg <= age_reg + 1'b1;
          end
          if (age_reg == AGE_MAX - 1'b1) begin
            valid_reg <= 1'b0;
            blank_reg <= 1'b0;
          end
`endif
        end
      end

      assign digit_val[4*gi +: 4] = val_reg;
      assign digit_valid[gi]      = valid_reg;
      assign digit_blank[gi]      = blank_reg;
      assign digit_err[gi]        = err_reg;
    end
  endgenerate

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the hex-to-seven-segment encoder.
- Watches a multiplexed, active-low seven-segment bus (segments plus per-digit anodes) and reconstructs the hex value shown on each digit.
- Used as an on-chip display monitor for self-check, score readback and bench scoreboarding of the display path.
- Debounces scan transitions with a stability counter and flags patterns that are not legal hex glyphs.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before capture (2..255).
- TIMEOUT_CYCLES, 1000000, refresh watchdog period; used only with SEGDEC_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- seg_n  in  7  active-low segments, bit6..bit0 = g,f,e,d,c,b,a.
- an_n  in  NUM_DIGITS  active-low digit enables, bit i = digit i.
- digit_val  out  4*NUM_DIGITS  decoded nibble per digit; digit i in bits [4i+3:4i].
- digit_valid  out  NUM_DIGITS  digit holds a captured legal glyph.
- digit_blank  out  NUM_DIGITS  last capture on the digit was all-off (7'h7F).
- digit_err  out  NUM_DIGITS  sticky flag: an illegal pattern was captured on the digit.
- upd  out  1  one-cycle pulse per capture.
- upd_idx  out  3  digit index of the current capture; valid while upd=1.

Behaviour:
- Reset: all outputs are 0; the sample register is 7'h7F / all-ones; the stability counter is 0.
- Input stage: {an_n, seg_n} is registered every cycle. The stability counter clears when the new sample differs from the held sample, and increments, saturating, when it matches.
- Capture: fires exactly once per stable window, on the edge where the counter reaches STABLE_CYCLES-1. An input applied before edge k becomes visible on the outputs after edge k+STABLE_CYCLES-1+1. Example: STABLE_CYCLES=4 with input before edge 0 gives outputs after edge 4.
- Capture requires exactly one an_n bit low.
  - All bits high (blanking gap) or several bits low (ghosting): no capture; the counter still runs.
- Decode table (seg_n -> nibble):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30
  - 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03
  - C=7'h46, d=7'h21, E=7'h06, F=7'h0E
- On capture of digit i:
  - Legal glyph: digit_val[i] = nibble, digit_valid[i] = 1, digit_blank[i] = 0.
  - Pattern 7'h7F: digit_blank[i] = 1, digit_valid[i] = 0, digit_val[i] unchanged.
  - Any other pattern: digit_err[i] = 1 (sticky until rst), digit_valid[i] = 0, digit_val[i] unchanged.
  - In every case upd = 1 for one cycle and upd_idx = i.
- Other digits' registers are never touched by a capture.
- Re-capture of an identical value still pulses upd. A repeated window on the same digit with no intervening change cannot re-fire, because the counter saturates.
- upd_idx is 0 when upd = 0.
- A change on the cycle the counter would reach STABLE_CYCLES-1 suppresses the capture and restarts the window.
- rst asserted mid-window aborts the window. No upd occurs on the reset edge or the following cycle.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: SEGDEC_TIMEOUT_EN.
- Enabled:
  - One refresh counter per digit, cleared on every capture of that digit.
  - After TIMEOUT_CYCLES cycles without a capture, digit_valid[i] and digit_blank[i] clear. digit_val[i] and digit_err[i] hold.
  - Each counter saturates at TIMEOUT_CYCLES.
- Disabled:
  - No refresh counters are present.
  - digit_valid holds until the next capture of that digit or rst.

Test Plan:
- rst, then an_n=4'b1110 and seg_n=7'h24 held 10 cycles -> upd pulses exactly once, 4 cycles after the first sampling edge; upd_idx=0; digit_val[3:0]=2; digit_valid=4'b0001.
- Scan digits 0..3 with 7'h79, 7'h30, 7'h08, 7'h21, 6 cycles each, separated by 2-cycle an_n=4'hF gaps -> digit_val=16'hDA31, digit_valid=4'hF, four upd pulses with idx 0,1,2,3.
- Glitch: digit 1 gets 7'h12 for 2 cycles, then 7'h02 held 6 cycles -> single capture, digit_val[7:4]=6.
- an_n=4'b1100 with 7'h00 held 8 cycles -> no upd, all outputs unchanged; then 7'h7F on digit 2 -> digit_blank=4'b0100, upd_idx=2.
- Digit 3 shows 7'h7E (illegal) -> digit_err[3]=1, digit_valid[3]=0. A later legal 7'h0E sets digit_val[15:12]=F and digit_valid[3]=1 while digit_err[3] stays 1 until rst.
- rst pulsed on the 3rd cycle of a stable window -> all outputs 0 and no upd. With SEGDEC_TIMEOUT_EN and TIMEOUT_CYCLES=50, a digit last captured 50 cycles earlier shows digit_valid=0 while digit_val is held.
